image_rom_arbiter: RTL

Shares one registered 48x64 sprite image ROM (12-bit address `{y[5:0],x[5:0]}`, 12-bit RGB444 data, one-cycle read latency) between `NUM_REQ` pixel-drawing requesters. It sits between the draw-pipeline stages and the single ROM instance. It grants at most one read per cycle using round-robin with bounded bursts, drives the ROM address, and returns each read result tagged with a one-hot valid to the requester that issued it.

---
 rtl/image_rom_pkg.sv | 14 +
 rtl/image_rom_arbiter_if.sv | 15 +
 rtl/image_rom_arb_pick.sv | 39 +++
 rtl/image_rom_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/image_rom_pkg.sv
// Shared constants and helpers for the 48x64 RGB444 sprite image ROM and its arbiter.
package image_rom_pkg;

    localparam int IMG_ADDR_W = 12;
    localparam int IMG_DATA_W = 12;
    localparam int IMG_W      = 48;
    localparam int IMG_H      = 64;

    // ROM address is row-major with a 64-wide stride: {y[5:0], x[5:0]}
    function automatic logic [IMG_ADDR_W-1:0] img_addr(input logic [5:0] x, input logic [5:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/image_rom_arbiter_if.sv
// Requester-side bus of the image ROM arbiter: request/address in, grant and tagged read data out.
interface image_rom_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 12
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/image_rom_arb_pick.sv
// Rotate-priority picker: one-hot grant to the first requester found searching upward from start.
module image_rom_arb_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] gnt
);
    localparam int SW = IDX_W + 1;

    logic [NUM_REQ-1:0] gnt_s;
    logic [SW-1:0]      sum_s;
    logic               found_s;

    // Walk start, start+1, ... modulo NUM_REQ and take the first asserted request
    always_comb begin
        gnt_s   = '0;
        sum_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = {1'b0, start} + SW'(i);
            if (sum_s >= SW'(NUM_REQ)) begin
                sum_s = sum_s - SW'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && req[sum_s[IDX_W-1:0]]) begin
                gnt_s[sum_s[IDX_W-1:0]] = 1'b1;
                found_s                 = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/image_rom_arbiter.sv
// Arbitrates NUM_REQ requesters onto one registered image ROM; round-robin with bounded bursts.
// Build option IMAGE_ROM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead.
module image_rom_arbiter
    import image_rom_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 4,
    parameter int ADDR_W    = IMG_ADDR_W,
    parameter int DATA_W    = IMG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    image_rom_arbiter_if.slave        bus,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_rgb
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   start_s;
    logic [NUM_REQ-1:0] pick_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [ADDR_W-1:0]  addr_sel_s;
    logic [ADDR_W-1:0]  rom_addr_s;
    logic [ADDR_W-1:0]  rom_addr_r;
    logic [NUM_REQ-1:0] rvalid_r;

    image_rom_arb_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (bus.req),
        .start (start_s),
        .gnt   (pick_s)
    );

    // Grant is held off while reset is asserted; address mux ORs the one-hot selection
    always_comb begin
        if (rst_n) begin
            gnt_s = pick_s;
        end else begin
            gnt_s = '0;
        end
        addr_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_sel_s = addr_sel_s | ({ADDR_W{gnt_s[i]}} & bus.addr[i*ADDR_W +: ADDR_W]);
        end
        if (|gnt_s) begin
            rom_addr_s = addr_sel_s;
        end else begin
            rom_addr_s = rom_addr_r;
        end
    end

    // Read tag and last ROM address; an in-flight read is dropped on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r   <= '0;
            rom_addr_r <= '0;
        end else begin
            rvalid_r   <= gnt_s;
            rom_addr_r <= rom_addr_s;
        end
    end

`ifdef IMAGE_ROM_ARB_FIXED_PRIO_EN
    assign start_s = '0;
`else
    localparam int BC_W = $clog2(MAX_BURST + 1);

    logic [IDX_W-1:0] holder_r;
    logic [BC_W-1:0]  burst_cnt_r;
    logic             started_r;
    logic             hold_ok_s;
    logic [IDX_W-1:0] gnt_idx_s;

    // started_r keeps the reset-value holder from claiming a burst, so requester 0 wins first
    always_comb begin
        hold_ok_s = started_r && bus.req[holder_r] && (burst_cnt_r < BC_W'(MAX_BURST));
        if (hold_ok_s) begin
            start_s = holder_r;
        end else if (holder_r == IDX_W'(NUM_REQ - 1)) begin
            start_s = '0;
        end else begin
            start_s = holder_r + IDX_W'(1);
        end
        gnt_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_idx_s = gnt_idx_s | ({IDX_W{gnt_s[i]}} & IDX_W'(i));
        end
    end

    // Holder and burst bookkeeping; an idle cycle ends the current burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holder_r    <= IDX_W'(NUM_REQ - 1);
            burst_cnt_r <= '0;
            started_r   <= 1'b0;
        end else if (|gnt_s) begin
            started_r <= 1'b1;
            if (gnt_idx_s == holder_r) begin
                if (burst_cnt_r != BC_W'(MAX_BURST)) begin
                    burst_cnt_r <= burst_cnt_r + BC_W'(1);
                end else begin
                    burst_cnt_r <= burst_cnt_r;
                end
            end else begin
                holder_r    <= gnt_idx_s;
                burst_cnt_r <= BC_W'(1);
            end
        end else begin
            burst_cnt_r <= '0;
        end
    end
`endif

    assign rom_addr   = rom_addr_s;
    assign bus.gnt    = gnt_s;
    assign bus.rvalid = rvalid_r;
    assign bus.rdata  = rom_rgb;

endmodule
